// File: rtl/neural_pkg.sv
// Shared types and default sizing for the neural blend datapath.
package neural_pkg;

    // Per-beat operation selector.
    typedef enum logic [1:0] {
        BLEND   = 2'd0,
        ABSDIFF = 2'd1,
        PASS_T  = 2'd2,
        PASS_T1 = 2'd3
    } blend_mode_t;

    localparam int unsigned MODE_W    = 2;
    localparam int unsigned DEF_W     = 8;
    localparam int unsigned DEF_C     = 3;
    localparam int unsigned DEF_CNT_W = 20;

endpackage

// File: rtl/neural_blend_pipe_if.sv
// Streaming bus between the frame fetch units, the blend pipe and the output formatter.
interface neural_blend_pipe_if #(
    parameter int unsigned W     = neural_pkg::DEF_W,
    parameter int unsigned C     = neural_pkg::DEF_C,
    parameter int unsigned CNT_W = neural_pkg::DEF_CNT_W
) ();
    import neural_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [C*W-1:0]     in_p_t;
    logic [C*W-1:0]     in_p_t1;
    logic [W-1:0]       in_mask;
    blend_mode_t        in_mode;
    logic               in_last;

    logic               out_valid;
    logic               out_ready;
    logic [C*W-1:0]     out_pixel;
    logic               out_last;

    logic [CNT_W-1:0]   frame_beats;
    logic               frame_done;

    // Producer/consumer side: drives input beats and downstream ready.
    modport master (
        output in_valid, in_p_t, in_p_t1, in_mask, in_mode, in_last, out_ready,
        input  in_ready, out_valid, out_pixel, out_last, frame_beats, frame_done
    );

    // Blend pipe side.
    modport slave (
        input  in_valid, in_p_t, in_p_t1, in_mask, in_mode, in_last, out_ready,
        output in_ready, out_valid, out_pixel, out_last, frame_beats, frame_done
    );

endinterface

// File: rtl/neural_blend_lane.sv
// One channel of the blend datapath: products in stage 1, round/shift/mux in stage 2.
module neural_blend_lane #(
    parameter int unsigned W = neural_pkg::DEF_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en1,
    input  logic                    en2,
    input  logic [W-1:0]            p_t,
    input  logic [W-1:0]            p_t1,
    input  logic [W-1:0]            mask,
    input  neural_pkg::blend_mode_t mode,
    output logic [W-1:0]            pixel
);
    import neural_pkg::*;

    localparam int unsigned MW = W + 1;
    localparam int unsigned PW = 2 * W + 1;
    localparam logic [PW-1:0] HALF = PW'(1) << (W - 1);

    logic [MW-1:0] m_exp_c;
    logic [MW-1:0] m_inv_c;

    logic [PW-1:0] prod_t_q;
    logic [PW-1:0] prod_t1_q;
    logic [W-1:0]  diff_q;
    logic [W-1:0]  p_t_q;
    logic [W-1:0]  p_t1_q;
    blend_mode_t   mode_q;

    logic [PW-1:0] sum_c;
    logic [W-1:0]  res_c;
    logic [W-1:0]  pixel_q;

    // Stretch the mask so all-ones becomes exactly 2^W, making both endpoints exact.
    assign m_exp_c = {1'b0, mask} + MW'(mask[W-1]);
    assign m_inv_c = {1'b1, {W{1'b0}}} - m_exp_c;

    // Stage 1: weighted products, absolute difference and pass-through operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_t_q  <= '0;
            prod_t1_q <= '0;
            diff_q    <= '0;
            p_t_q     <= '0;
            p_t1_q    <= '0;
            mode_q    <= BLEND;
        end else if (en1) begin
            prod_t_q  <= PW'(p_t) * PW'(m_exp_c);
            prod_t1_q <= PW'(p_t1) * PW'(m_inv_c);
            diff_q    <= (p_t >= p_t1) ? (p_t - p_t1) : (p_t1 - p_t);
            p_t_q     <= p_t;
            p_t1_q    <= p_t1;
            mode_q    <= mode;
        end
    end

    // Stage 2 combinational: round-to-nearest blend and mode select.
    always_comb begin
        sum_c = prod_t_q + prod_t1_q + HALF;
        res_c = '0;
        case (mode_q)
            BLEND:   res_c = W'(sum_c >> W);
            ABSDIFF: res_c = diff_q;
            PASS_T:  res_c = p_t_q;
            PASS_T1: res_c = p_t1_q;
            default: res_c = '0;
        endcase
    end

    // Stage 2 register: the lane's output pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_q <= '0;
        end else if (en2) begin
            pixel_q <= res_c;
        end
    end

    assign pixel = pixel_q;

endmodule

// File: rtl/neural_blend_pipe.sv
// Two-stage streaming blender of two C-channel pixel streams with frame beat counting.
module neural_blend_pipe #(
    parameter int unsigned W     = neural_pkg::DEF_W,
    parameter int unsigned C     = neural_pkg::DEF_C,
    parameter int unsigned CNT_W = neural_pkg::DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    neural_blend_pipe_if.slave  bus
);
    import neural_pkg::*;

    logic             v1;
    logic             v2;
    logic             last1;
    logic             last2;
    logic             load1_c;
    logic             load2_c;
    logic             xfer_c;
    logic [C*W-1:0]   pixel_c;

    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] frame_beats_q;
    logic             frame_done_q;

    // A stage loads when it is empty or its successor is taking its contents.
    assign load2_c = !v2 || bus.out_ready;
    assign load1_c = !v1 || load2_c;
    assign xfer_c  = v2 && bus.out_ready;

    assign bus.in_ready    = load1_c;
    assign bus.out_valid   = v2;
    assign bus.out_last    = last2;
    assign bus.out_pixel   = pixel_c;
    assign bus.frame_beats = frame_beats_q;
    assign bus.frame_done  = frame_done_q;

    // Stage valid bits and the last-flag pipe, moving in step with the lane registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            last1 <= 1'b0;
            last2 <= 1'b0;
        end else begin
            if (load1_c) begin
                v1    <= bus.in_valid;
                last1 <= bus.in_last;
            end
            if (load2_c) begin
                v2    <= v1;
                last2 <= last1;
            end
        end
    end

    // One arithmetic lane per channel, all sharing mask and mode.
    for (genvar k = 0; k < int'(C); k++) begin : g_lane
        neural_blend_lane #(
            .W (W)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .en1   (load1_c),
            .en2   (load2_c),
            .p_t   (bus.in_p_t[k*W +: W]),
            .p_t1  (bus.in_p_t1[k*W +: W]),
            .mask  (bus.in_mask),
            .mode  (bus.in_mode),
            .pixel (pixel_c[k*W +: W])
        );
    end

    // Count output transfers; publish the count and pulse done on the last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt      <= '0;
            frame_beats_q <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (xfer_c) begin
                if (last2) begin
                    frame_beats_q <= beat_cnt + CNT_W'(1);
                    beat_cnt      <= '0;
                    frame_done_q  <= 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_neural_blend_pipe.sv
// Self-checking bench for neural_blend_pipe: W=8/C=3 instance plus a W=4/C=1 instance for the sweep.
module tb_neural_blend_pipe;
    import neural_pkg::*;

    localparam int unsigned AW  = 8;
    localparam int unsigned AC  = 3;
    localparam int unsigned ACW = 20;
    localparam int unsigned BW  = 4;
    localparam int unsigned BC  = 1;
    localparam int unsigned BCW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    always #5 clk = ~clk;

    neural_blend_pipe_if #(.W(AW), .C(AC), .CNT_W(ACW)) ia ();
    neural_blend_pipe_if #(.W(BW), .C(BC), .CNT_W(BCW)) ib ();

    neural_blend_pipe #(.W(AW), .C(AC), .CNT_W(ACW)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    neural_blend_pipe #(.W(BW), .C(BC), .CNT_W(BCW)) dut_b (.clk(clk), .rst(rst), .bus(ib));

    // Reference: per-channel arithmetic straight from the blend rules.
    function automatic logic [23:0] ref_pix(int w, int c, logic [23:0] pt, logic [23:0] pt1,
                                            int mask, int mode);
        logic [23:0] r;
        int full, a, b, mp, v;
        r    = '0;
        full = 1 << w;
        for (int k = 0; k < c; k++) begin
            a = int'(pt[k*w +: 8]) % full;
            b = int'(pt1[k*w +: 8]) % full;
            case (mode)
                0: begin
                    mp = mask + ((mask >= full / 2) ? 1 : 0);
                    v  = (a * mp + b * (full - mp) + full / 2) / full;
                end
                1:       v = (a > b) ? a - b : b - a;
                2:       v = a;
                default: v = b;
            endcase
            r = r | (24'(v) << (k * w));
        end
        return r;
    endfunction

    task automatic drive_a(bit v, logic [23:0] pt, logic [23:0] pt1, logic [7:0] m, int mode, bit last);
        ia.in_valid = v;
        ia.in_p_t   = pt;
        ia.in_p_t1  = pt1;
        ia.in_mask  = m;
        ia.in_mode  = blend_mode_t'(mode[1:0]);
        ia.in_last  = last;
    endtask

    // Samples the handshakes just before the next edge, then steps past it.
    task automatic tick_a(output bit acc, output bit xfer, output logic [23:0] opix, output bit olast);
        #1;
        acc   = ia.in_valid && ia.in_ready;
        xfer  = ia.out_valid && ia.out_ready;
        opix  = ia.out_pixel;
        olast = ia.out_last;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_b(output bit acc, output bit xfer, output logic [3:0] opix);
        #1;
        acc  = ib.in_valid && ib.in_ready;
        xfer = ib.out_valid && ib.out_ready;
        opix = ib.out_pixel;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_a(1'b1, 24'h123456, 24'h654321, 8'h80, 0, 1'b1);
        ia.out_ready = 1'b1;
        ib.in_valid = 1'b0; ib.in_p_t = '0; ib.in_p_t1 = '0; ib.in_mask = '0;
        ib.in_mode = BLEND; ib.in_last = 1'b0; ib.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++; if (ia.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", ia.out_valid); else pass_cnt++;
        chk_cnt++; if (ia.out_pixel !== 24'h0) $display("FAIL reset_out_pixel: got %h expected 0", ia.out_pixel); else pass_cnt++;
        chk_cnt++; if (ia.out_last !== 1'b0) $display("FAIL reset_out_last: got %b expected 0", ia.out_last); else pass_cnt++;
        chk_cnt++; if (ia.frame_beats !== 20'd0) $display("FAIL reset_frame_beats: got %0d expected 0", ia.frame_beats); else pass_cnt++;
        chk_cnt++; if (ia.frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b expected 0", ia.frame_done); else pass_cnt++;
        chk_cnt++; if (ia.in_ready !== 1'b1) $display("FAIL reset_in_ready_held: got %b expected 1", ia.in_ready); else pass_cnt++;
        rst = 1'b0;
        ia.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_cnt++; if (ia.out_valid !== 1'b0) $display("FAIL reset_dropped_beat: cycle %0d out_valid got %b expected 0", i, ia.out_valid); else pass_cnt++;
        end
        chk_cnt++; if (ia.in_ready !== 1'b1) $display("FAIL reset_in_ready_after: got %b expected 1", ia.in_ready); else pass_cnt++;
    endtask

    task automatic test_blend_directed();
        int masks[3] = '{0, 255, 128};
        int exps[3]  = '{200, 100, 150};
        bit acc, xfer, olast;
        logic [23:0] opix, pt, pt1, want;
        ia.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pt   = {16'($urandom), 8'd100};
            pt1  = {16'($urandom), 8'd200};
            want = ref_pix(AW, AC, pt, pt1, masks[i], 0);
            drive_a(1'b1, pt, pt1, 8'(masks[i]), 0, i == 2);
            tick_a(acc, xfer, opix, olast);
            ia.in_valid = 1'b0;
            chk_cnt++; if (acc !== 1'b1) $display("FAIL blend_accept[%0d]: got %b expected 1", i, acc); else pass_cnt++;
            chk_cnt++; if (ia.out_valid !== 1'b0) $display("FAIL blend_early_valid[%0d]: got %b expected 0", i, ia.out_valid); else pass_cnt++;
            tick_a(acc, xfer, opix, olast);
            chk_cnt++; if (ia.out_valid !== 1'b1) $display("FAIL blend_valid[%0d]: got %b expected 1", i, ia.out_valid); else pass_cnt++;
            chk_cnt++; if (ia.out_pixel[7:0] !== 8'(exps[i])) $display("FAIL blend_ch0[%0d]: got %0d expected %0d", i, ia.out_pixel[7:0], exps[i]); else pass_cnt++;
            chk_cnt++; if (ia.out_pixel !== want) $display("FAIL blend_pixel[%0d]: got %h expected %h", i, ia.out_pixel, want); else pass_cnt++;
            chk_cnt++; if (ia.out_last !== (i == 2)) $display("FAIL blend_last[%0d]: got %b expected %b", i, ia.out_last, i == 2); else pass_cnt++;
            tick_a(acc, xfer, opix, olast);
            chk_cnt++; if (xfer !== 1'b1 || opix !== want || olast !== (i == 2)) $display("FAIL blend_drain[%0d]: got xfer %b pix %h last %b expected 1 %h %b", i, xfer, opix, olast, want, i == 2); else pass_cnt++;
        end
        chk_cnt++; if (ia.frame_done !== 1'b1 || ia.frame_beats !== 20'd3) $display("FAIL blend_frame: got done %b beats %0d expected 1 3", ia.frame_done, ia.frame_beats); else pass_cnt++;
    endtask

    task automatic test_absdiff_pass();
        logic [23:0] pts[3], pt1s[3], wants[3];
        int modes[3] = '{1, 2, 3};
        bit acc, xfer, olast;
        logic [23:0] opix;
        int got = 0;
        int first_x = -1;
        int last_x = -1;
        pts[0] = {8'd10, 8'd200, 8'd50}; pt1s[0] = {8'd30, 8'd100, 8'd50}; wants[0] = {8'd20, 8'd100, 8'd0};
        pts[1] = 24'($urandom); pt1s[1] = 24'($urandom); wants[1] = pts[1];
        pts[2] = 24'($urandom); pt1s[2] = 24'($urandom); wants[2] = pt1s[2];
        ia.out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc < 3) drive_a(1'b1, pts[cyc], pt1s[cyc], 8'($urandom), modes[cyc], cyc == 2);
            else ia.in_valid = 1'b0;
            tick_a(acc, xfer, opix, olast);
            if (cyc < 3) begin
                chk_cnt++; if (acc !== 1'b1) $display("FAIL mode_accept[%0d]: got %b expected 1", cyc, acc); else pass_cnt++;
            end
            if (xfer) begin
                if (got < 3) begin
                    chk_cnt++; if (opix !== wants[got]) $display("FAIL mode_pixel[%0d]: got %h expected %h", got, opix, wants[got]); else pass_cnt++;
                    chk_cnt++; if (olast !== (got == 2)) $display("FAIL mode_last[%0d]: got %b expected %b", got, olast, got == 2); else pass_cnt++;
                end
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
                got++;
            end
        end
        chk_cnt++; if (got != 3) $display("FAIL mode_count: got %0d beats expected 3", got); else pass_cnt++;
        chk_cnt++; if (last_x - first_x != 2) $display("FAIL mode_no_bubble: got span %0d expected 2", last_x - first_x); else pass_cnt++;
        chk_cnt++; if (ia.frame_beats !== 20'd3) $display("FAIL mode_frame_beats: got %0d expected 3", ia.frame_beats); else pass_cnt++;
    endtask

    task automatic test_backpressure_stream();
        logic [23:0] exp_q[$];
        bit expl_q[$];
        logic [23:0] pt, pt1, want, opix;
        logic [7:0] m;
        int mode = 0;
        bit last = 1'b0, have = 1'b0, acc, xfer, olast, wl;
        int sent = 0, got = 0;
        for (int cyc = 0; cyc < 400 && (sent < 16 || exp_q.size() > 0); cyc++) begin
            if (!have && sent < 16) begin
                pt = 24'($urandom); pt1 = 24'($urandom); m = 8'($urandom);
                mode = int'($urandom_range(0, 3)); last = (sent == 15); have = 1'b1;
            end
            if (have) drive_a(1'b1, pt, pt1, m, mode, last);
            else ia.in_valid = 1'b0;
            ia.out_ready = 1'($urandom_range(0, 1));
            #1;
            chk_cnt++;
            if (ia.in_ready !== (ia.out_ready || exp_q.size() < 2))
                $display("FAIL stream_in_ready[%0d]: got %b expected %b (held %0d)", cyc, ia.in_ready, ia.out_ready || exp_q.size() < 2, exp_q.size());
            else pass_cnt++;
            tick_a(acc, xfer, opix, olast);
            if (xfer) begin
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stream_spurious: got beat %h expected none", opix);
                end else begin
                    want = exp_q.pop_front();
                    wl   = expl_q.pop_front();
                    if (opix !== want || olast !== wl) $display("FAIL stream_beat[%0d]: got %h/%b expected %h/%b", got, opix, olast, want, wl);
                    else pass_cnt++;
                    if (wl) begin
                        chk_cnt++; if (ia.frame_done !== 1'b1 || ia.frame_beats !== 20'd16) $display("FAIL stream_frame: got done %b beats %0d expected 1 16", ia.frame_done, ia.frame_beats); else pass_cnt++;
                    end
                    got++;
                end
            end
            if (acc) begin
                exp_q.push_back(ref_pix(AW, AC, pt, pt1, int'(m), mode));
                expl_q.push_back(last);
                sent++;
                have = 1'b0;
            end
        end
        chk_cnt++; if (got != 16 || exp_q.size() != 0) $display("FAIL stream_complete: got %0d beats (%0d pending) expected 16 (0)", got, exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_frames();
        bit acc, xfer, olast, exp_done;
        logic [23:0] opix;
        int fb[2] = '{0, 0};
        int done_cnt = 0, sent = 0;
        ia.out_ready = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (sent < 8) drive_a(1'b1, 24'($urandom), 24'($urandom), 8'($urandom), int'($urandom_range(0, 3)), sent == 4 || sent == 7);
            else ia.in_valid = 1'b0;
            tick_a(acc, xfer, opix, olast);
            if (acc) sent++;
            exp_done = xfer && olast;
            chk_cnt++; if (ia.frame_done !== exp_done) $display("FAIL frame_done[%0d]: got %b expected %b", cyc, ia.frame_done, exp_done); else pass_cnt++;
            if (ia.frame_done === 1'b1) begin
                if (done_cnt < 2) fb[done_cnt] = int'(ia.frame_beats);
                done_cnt++;
            end
        end
        chk_cnt++; if (done_cnt != 2) $display("FAIL frame_pulses: got %0d expected 2", done_cnt); else pass_cnt++;
        chk_cnt++; if (fb[0] != 5) $display("FAIL frame_beats_first: got %0d expected 5", fb[0]); else pass_cnt++;
        chk_cnt++; if (fb[1] != 3) $display("FAIL frame_beats_second: got %0d expected 3", fb[1]); else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        bit acc, xfer, olast;
        logic [23:0] opix;
        int done_cnt = 0, fb = 0, sent = 0;
        ia.out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc < 2) drive_a(1'b1, 24'($urandom), 24'($urandom), 8'($urandom), 0, 1'b0);
            else ia.in_valid = 1'b0;
            tick_a(acc, xfer, opix, olast);
        end
        ia.out_ready = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            drive_a(1'b1, 24'($urandom), 24'($urandom), 8'($urandom), 0, 1'b0);
            tick_a(acc, xfer, opix, olast);
        end
        #1;
        chk_cnt++; if (ia.in_ready !== 1'b0 || ia.out_valid !== 1'b1) $display("FAIL midrst_full: got in_ready %b out_valid %b expected 0 1", ia.in_ready, ia.out_valid); else pass_cnt++;
        #1;
        rst = 1'b1;
        #1;
        chk_cnt++; if (ia.out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b expected 0", ia.out_valid); else pass_cnt++;
        chk_cnt++; if (ia.out_pixel !== 24'h0 || ia.out_last !== 1'b0) $display("FAIL midrst_out_data: got %h/%b expected 0/0", ia.out_pixel, ia.out_last); else pass_cnt++;
        chk_cnt++; if (ia.in_ready !== 1'b1 || ia.frame_done !== 1'b0) $display("FAIL midrst_ready_done: got %b/%b expected 1/0", ia.in_ready, ia.frame_done); else pass_cnt++;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ia.in_valid  = 1'b0;
        ia.out_ready = 1'b1;
        chk_cnt++; if (ia.frame_beats !== 20'd0) $display("FAIL midrst_frame_beats: got %0d expected 0", ia.frame_beats); else pass_cnt++;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (sent < 4) drive_a(1'b1, 24'($urandom), 24'($urandom), 8'($urandom), 0, sent == 3);
            else ia.in_valid = 1'b0;
            tick_a(acc, xfer, opix, olast);
            if (acc) sent++;
            if (ia.frame_done === 1'b1) begin
                fb = int'(ia.frame_beats);
                done_cnt++;
            end
        end
        chk_cnt++; if (done_cnt != 1) $display("FAIL midrst_pulses: got %0d expected 1", done_cnt); else pass_cnt++;
        chk_cnt++; if (fb != 4) $display("FAIL midrst_next_frame: got %0d expected 4", fb); else pass_cnt++;
    endtask

    task automatic test_w4_sweep();
        int qe[$], qa[$], qb[$], qm[$];
        int pa = 0, pb = 0, pm = 0, e, a, b, mk;
        int sent = 0, got = 0, cycles = 0, bad = 0;
        bit acc, xfer;
        logic [3:0] opix;
        ib.out_ready = 1'b1;
        for (int cyc = 0; cyc < 4200 && (sent < 4096 || qe.size() > 0); cyc++) begin
            if (sent < 4096) begin
                pa = (sent >> 8) & 15; pb = (sent >> 4) & 15; pm = sent & 15;
                ib.in_valid = 1'b1; ib.in_p_t = 4'(pa); ib.in_p_t1 = 4'(pb);
                ib.in_mask = 4'(pm); ib.in_mode = BLEND; ib.in_last = 1'b0;
            end else begin
                ib.in_valid = 1'b0;
            end
            tick_b(acc, xfer, opix);
            cycles++;
            if (xfer && qe.size() > 0) begin
                e = qe.pop_front(); a = qa.pop_front(); b = qb.pop_front(); mk = qm.pop_front();
                chk_cnt++;
                if (opix !== 4'(e)) begin
                    if (bad < 10) $display("FAIL sweep_blend p_t=%0d p_t1=%0d mask=%0d: got %0d expected %0d", a, b, mk, opix, e);
                    bad++;
                end else pass_cnt++;
                if (mk == 0) begin
                    chk_cnt++; if (opix !== 4'(b)) $display("FAIL sweep_mask0 p_t=%0d p_t1=%0d: got %0d expected %0d", a, b, opix, b); else pass_cnt++;
                end
                if (mk == 15) begin
                    chk_cnt++; if (opix !== 4'(a)) $display("FAIL sweep_mask15 p_t=%0d p_t1=%0d: got %0d expected %0d", a, b, opix, a); else pass_cnt++;
                end
                got++;
            end
            if (acc) begin
                qe.push_back(int'(ref_pix(BW, BC, 24'(pa), 24'(pb), pm, 0)));
                qa.push_back(pa); qb.push_back(pb); qm.push_back(pm);
                sent++;
            end
        end
        chk_cnt++; if (got != 4096) $display("FAIL sweep_count: got %0d expected 4096", got); else pass_cnt++;
        chk_cnt++; if (cycles != 4098) $display("FAIL sweep_throughput: got %0d cycles expected 4098", cycles); else pass_cnt++;
        chk_cnt++; if (ib.frame_done !== 1'b0 || ib.frame_beats !== 8'd0) $display("FAIL sweep_no_frame: got %b/%0d expected 0/0", ib.frame_done, ib.frame_beats); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_blend_directed();
        test_absdiff_pass();
        test_backpressure_stream();
        test_frames();
        test_reset_midframe();
        test_w4_sweep();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, chk_cnt);
        $fatal(1, "time limit");
    end

endmodule
